// File: rtl/instr_sequencer_if.sv
// Instruction- and data-memory handshake bundle between the sequencer (master) and memories (slave).
interface instr_sequencer_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;

    modport master (
        output imem_req, imem_addr, dmem_req, dmem_we, dmem_addr,
        input  imem_ack, imem_rdata, dmem_ack, dmem_rdata
    );

    modport slave (
        input  imem_req, imem_addr, dmem_req, dmem_we, dmem_addr,
        output imem_ack, imem_rdata, dmem_ack, dmem_rdata
    );
endinterface

// File: rtl/instr_sequencer.sv
// Multi-cycle MIPS sequencer: FETCH/DECODE/EXEC/MEM/WB/RETIRE with halt and retired counter.
module instr_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned CNT_W    = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    instr_sequencer_if.master    bus,
    output logic [31:0]          instr,
    input  logic                 dec_wr_en,
    input  logic                 dec_load,
    input  logic                 dec_store,
    input  logic [31:0]          alu_result,
    input  logic                 br_taken,
    input  logic [31:0]          br_target,
    output logic                 rf_we,
    output logic [31:0]          rf_wdata,
    output logic [31:0]          pc,
    input  logic                 halt_req,
    output logic                 halted,
    output logic [CNT_W-1:0]     retired
);
    localparam int unsigned XLEN = 32;

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_RETIRE, S_HALT
    } state_e;

    state_e            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   npc_q, npc_d;
    logic [XLEN-1:0]   instr_q, instr_d;
    logic [XLEN-1:0]   dmem_addr_q, dmem_addr_d;
    logic [XLEN-1:0]   rf_wdata_q, rf_wdata_d;
    logic [CNT_W-1:0]  retired_q, retired_d;
    logic              store_q, store_d;
    logic              imem_req_q, imem_req_d;
    logic              dmem_req_q, dmem_req_d;
    logic              dmem_we_q, dmem_we_d;
    logic              rf_we_q, rf_we_d;
    logic              halted_q, halted_d;

    // State and registered outputs; reset drops every request in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_FETCH;
            pc_q        <= RESET_PC;
            npc_q       <= RESET_PC;
            instr_q     <= '0;
            dmem_addr_q <= '0;
            rf_wdata_q  <= '0;
            retired_q   <= '0;
            store_q     <= 1'b0;
            imem_req_q  <= 1'b0;
            dmem_req_q  <= 1'b0;
            dmem_we_q   <= 1'b0;
            rf_we_q     <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            npc_q       <= npc_d;
            instr_q     <= instr_d;
            dmem_addr_q <= dmem_addr_d;
            rf_wdata_q  <= rf_wdata_d;
            retired_q   <= retired_d;
            store_q     <= store_d;
            imem_req_q  <= imem_req_d;
            dmem_req_q  <= dmem_req_d;
            dmem_we_q   <= dmem_we_d;
            rf_we_q     <= rf_we_d;
            halted_q    <= halted_d;
        end
    end

    // Next-state and datapath updates; strobes are decoded from the next state so they are flopped.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        npc_d       = npc_q;
        instr_d     = instr_q;
        dmem_addr_d = dmem_addr_q;
        rf_wdata_d  = rf_wdata_q;
        retired_d   = retired_q;
        store_d     = store_q;

        case (state_q)
            S_FETCH: begin
                if (bus.imem_ack) begin
                    instr_d = bus.imem_rdata;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: state_d = S_EXEC;
            S_EXEC: begin
                dmem_addr_d = alu_result;
                rf_wdata_d  = alu_result;
                npc_d       = br_taken ? br_target : pc_q + XLEN'(4);
                // load+store together resolves as a store
                store_d     = dec_store;
                if (dec_load || dec_store) state_d = S_MEM;
                else if (dec_wr_en)        state_d = S_WB;
                else                       state_d = S_RETIRE;
            end
            S_MEM: begin
                if (bus.dmem_ack) begin
                    if (store_q) begin
                        state_d = S_RETIRE;
                    end else begin
                        rf_wdata_d = bus.dmem_rdata;
                        state_d    = S_WB;
                    end
                end
            end
            S_WB: state_d = S_RETIRE;
            S_RETIRE: begin
                pc_d      = npc_q;
                retired_d = retired_q + CNT_W'(1);
                state_d   = halt_req ? S_HALT : S_FETCH;
            end
            S_HALT: begin
                if (!halt_req) state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase

        imem_req_d = (state_d == S_FETCH);
        dmem_req_d = (state_d == S_MEM);
        dmem_we_d  = (state_d == S_MEM) && store_d;
        rf_we_d    = (state_d == S_WB);
        halted_d   = (state_d == S_HALT);
    end

    assign bus.imem_req  = imem_req_q;
    assign bus.imem_addr = pc_q;
    assign bus.dmem_req  = dmem_req_q;
    assign bus.dmem_we   = dmem_we_q;
    assign bus.dmem_addr = dmem_addr_q;
    assign instr         = instr_q;
    assign rf_we         = rf_we_q;
    assign rf_wdata      = rf_wdata_q;
    assign pc            = pc_q;
    assign halted        = halted_q;
    assign retired       = retired_q;
endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer; narrow retired counter so its wrap is reachable.
module tb_instr_sequencer;
    localparam int unsigned CW = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [31:0]   instr;
    logic          dec_wr_en, dec_load, dec_store;
    logic [31:0]   alu_result;
    logic          br_taken;
    logic [31:0]   br_target;
    logic          rf_we;
    logic [31:0]   rf_wdata;
    logic [31:0]   pc;
    logic          halt_req;
    logic          halted;
    logic [CW-1:0] retired;

    int errors = 0;
    int checks = 0;

    instr_sequencer_if bus ();

    instr_sequencer #(.RESET_PC(32'h0000_0000), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .instr(instr),
        .dec_wr_en(dec_wr_en), .dec_load(dec_load), .dec_store(dec_store),
        .alu_result(alu_result), .br_taken(br_taken), .br_target(br_target),
        .rf_we(rf_we), .rf_wdata(rf_wdata), .pc(pc),
        .halt_req(halt_req), .halted(halted), .retired(retired)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present an instruction on the fetch bus for one edge (zero-wait fetch), leaving DUT in DECODE.
    task automatic fetch(input logic [31:0] word);
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = word;
        tick();
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = 32'h0;
    endtask

    task automatic set_dec(input logic wr, input logic ld, input logic st, input logic [31:0] alu);
        dec_wr_en  = wr;
        dec_load   = ld;
        dec_store  = st;
        alu_result = alu;
    endtask

    initial begin
        rst_n = 1'b0;
        bus.imem_ack = 1'b0; bus.imem_rdata = 32'h0;
        bus.dmem_ack = 1'b0; bus.dmem_rdata = 32'h0;
        set_dec(1'b0, 1'b0, 1'b0, 32'h0);
        br_taken = 1'b0; br_target = 32'h0; halt_req = 1'b0;

        tick(); tick();
        chk("rst_imem_req", 32'(bus.imem_req), 32'd0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_retired", 32'(retired), 32'd0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_rf_wdata", rf_wdata, 32'h0);
        rst_n = 1'b1;
        tick();
        chk("fetch0_req", 32'(bus.imem_req), 32'd1);
        chk("fetch0_addr", bus.imem_addr, 32'h0);

        // ADDI: FETCH, DECODE, EXEC, WB, RETIRE
        set_dec(1'b1, 1'b0, 1'b0, 32'h0000_0005);
        fetch(32'h2008_0005);
        chk("addi_instr", instr, 32'h2008_0005);
        chk("addi_req_drop", 32'(bus.imem_req), 32'd0);
        tick();                                  // EXEC
        chk("addi_exec_rfwe", 32'(rf_we), 32'd0);
        tick();                                  // WB
        chk("addi_wb_rfwe", 32'(rf_we), 32'd1);
        chk("addi_wdata", rf_wdata, 32'h0000_0005);
        chk("addi_wb_dmem", 32'(bus.dmem_req), 32'd0);
        tick();                                  // RETIRE
        chk("addi_ret_rfwe", 32'(rf_we), 32'd0);
        tick();                                  // FETCH
        chk("addi_pc", pc, 32'h4);
        chk("addi_retired", 32'(retired), 32'd1);
        chk("addi_fetch_req", 32'(bus.imem_req), 32'd1);

        // LW with dmem_ack on the fourth MEM cycle
        set_dec(1'b1, 1'b1, 1'b0, 32'h0000_0100);
        fetch(32'h8C09_0010);
        tick();                                  // EXEC
        tick();                                  // MEM cycle 1
        for (int i = 0; i < 4; i++) begin
            chk("lw_dmem_req", 32'(bus.dmem_req), 32'd1);
            chk("lw_dmem_we", 32'(bus.dmem_we), 32'd0);
            chk("lw_dmem_addr", bus.dmem_addr, 32'h0000_0100);
            chk("lw_mem_rfwe", 32'(rf_we), 32'd0);
            if (i < 3) tick();
        end
        bus.dmem_ack = 1'b1; bus.dmem_rdata = 32'hDEAD_BEEF;
        tick();                                  // WB
        bus.dmem_ack = 1'b0; bus.dmem_rdata = 32'h0;
        chk("lw_wb_rfwe", 32'(rf_we), 32'd1);
        chk("lw_wdata", rf_wdata, 32'hDEAD_BEEF);
        chk("lw_wb_dmem", 32'(bus.dmem_req), 32'd0);
        tick();                                  // RETIRE
        chk("lw_ret_rfwe", 32'(rf_we), 32'd0);
        tick();
        chk("lw_pc", pc, 32'h8);
        chk("lw_retired", 32'(retired), 32'd2);

        // SW, zero-wait; stray dmem_ack during EXEC must be ignored
        set_dec(1'b0, 1'b0, 1'b1, 32'h0000_0200);
        fetch(32'hAC0A_0020);
        bus.dmem_ack = 1'b1;
        tick();                                  // EXEC
        chk("sw_exec_dmem", 32'(bus.dmem_req), 32'd0);
        tick();                                  // MEM (ack held -> completes now)
        chk("sw_dmem_req", 32'(bus.dmem_req), 32'd1);
        chk("sw_dmem_we", 32'(bus.dmem_we), 32'd1);
        chk("sw_dmem_addr", bus.dmem_addr, 32'h0000_0200);
        chk("sw_mem_rfwe", 32'(rf_we), 32'd0);
        tick();                                  // RETIRE
        bus.dmem_ack = 1'b0;
        chk("sw_ret_rfwe", 32'(rf_we), 32'd0);
        chk("sw_ret_dmem", 32'(bus.dmem_req), 32'd0);
        tick();
        chk("sw_pc", pc, 32'hC);
        chk("sw_retired", 32'(retired), 32'd3);

        // BEQ taken to 0x40: FETCH, DECODE, EXEC, RETIRE
        set_dec(1'b0, 1'b0, 1'b0, 32'h0);
        br_taken = 1'b1; br_target = 32'h0000_0040;
        fetch(32'h1000_000C);
        tick();                                  // EXEC
        tick();                                  // RETIRE
        br_taken = 1'b0; br_target = 32'h0;
        chk("beq_rfwe", 32'(rf_we), 32'd0);
        chk("beq_dmem", 32'(bus.dmem_req), 32'd0);
        tick();
        chk("beq_pc", pc, 32'h40);
        chk("beq_retired", 32'(retired), 32'd4);

        // halt_req raised in EXEC: instruction completes, then HALT
        set_dec(1'b1, 1'b0, 1'b0, 32'h0000_0007);
        fetch(32'h2008_0007);
        tick();                                  // EXEC
        halt_req = 1'b1;
        tick();                                  // WB
        chk("halt_wb_rfwe", 32'(rf_we), 32'd1);
        chk("halt_wb_halted", 32'(halted), 32'd0);
        tick();                                  // RETIRE
        tick();                                  // HALT
        chk("halt_halted", 32'(halted), 32'd1);
        chk("halt_no_req", 32'(bus.imem_req), 32'd0);
        chk("halt_retired", 32'(retired), 32'd5);
        chk("halt_pc", pc, 32'h44);
        tick();
        chk("halt_stay", 32'(halted), 32'd1);
        chk("halt_stay_req", 32'(bus.imem_req), 32'd0);
        halt_req = 1'b0;
        tick();                                  // FETCH
        chk("resume_halted", 32'(halted), 32'd0);
        chk("resume_req", 32'(bus.imem_req), 32'd1);
        chk("resume_addr", bus.imem_addr, 32'h44);

        // Jump to 0xFFFF_FFFC, then a nop wraps pc to 0 and retired hits all-ones
        set_dec(1'b0, 1'b0, 1'b0, 32'h0);
        br_taken = 1'b1; br_target = 32'hFFFF_FFFC;
        fetch(32'h0800_0000);
        tick(); tick();
        br_taken = 1'b0; br_target = 32'h0;
        tick();
        chk("jmp_pc", pc, 32'hFFFF_FFFC);
        chk("jmp_retired", 32'(retired), 32'd6);
        fetch(32'h0000_0000);
        tick(); tick(); tick();
        chk("wrap_pc", pc, 32'h0);
        chk("ones_retired", 32'(retired), 32'd7);
        fetch(32'h0000_0000);
        tick(); tick(); tick();
        chk("wrap_retired", 32'(retired), 32'd0);
        chk("post_wrap_pc", pc, 32'h4);

        // Async reset in the middle of a MEM access
        set_dec(1'b0, 1'b0, 1'b1, 32'h0000_0300);
        fetch(32'hAC0B_0030);
        tick(); tick();                          // EXEC, MEM
        chk("mid_mem_req", 32'(bus.dmem_req), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rstmid_dmem_req", 32'(bus.dmem_req), 32'd0);
        chk("rstmid_imem_req", 32'(bus.imem_req), 32'd0);
        chk("rstmid_rfwe", 32'(rf_we), 32'd0);
        chk("rstmid_pc", pc, 32'h0);
        chk("rstmid_retired", 32'(retired), 32'd0);
        set_dec(1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("rstmid_refetch", 32'(bus.imem_req), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
